// File: rtl/seq_step_counter_if.sv
// Bus between the multiplier control FSM (master) and the step counter (slave).
interface seq_step_counter_if #(
    parameter int WIDTH_C = 4
);
    // start is taken in any cycle the counter is not busy and abort is low.
    // term is sampled with it. busy stays high until the last step or an abort.
    // done is a single-cycle pulse after the last step. abort never produces done.
    logic               start;
    logic [WIDTH_C-1:0] term;
    logic               add_shift;
    logic               shift;
    logic               abort;
    logic [WIDTH_C-1:0] count;
    logic               count_check;
    logic               busy;
    logic               done;
    logic               step_err;
    logic [WIDTH_C:0]   add_steps;

    modport master (
        output start, term, add_shift, shift, abort,
        input  count, count_check, busy, done, step_err, add_steps
    );

    modport slave (
        input  start, term, add_shift, shift, abort,
        output count, count_check, busy, done, step_err, add_steps
    );
endinterface

// File: rtl/seq_step_counter.sv
// Step counter for one multiply operation: term+1 steps, start/busy/done, abort, sticky step_err.
// Define SEQ_STEP_COUNTER_STATS_EN to build the add_shift step counter behind add_steps.
module seq_step_counter #(
    parameter int WIDTH_C = 4
) (
    input  logic                clk,
    input  logic                reset,
    seq_step_counter_if.slave   bus,
    output logic [1:0]          dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH_C-1:0] count_q;
    logic [WIDTH_C-1:0] term_q;
    logic               busy_q;
    logic               done_q;
    logic               step_err_q;

    logic step_w;
    logic start_acc_w;
    logic err_set_w;

    assign step_w      = bus.add_shift | bus.shift;
    assign start_acc_w = bus.start & ~bus.abort & (state_q != RUN);
    // Both strobes at once is always a protocol slip; any strobe outside RUN is one too.
    assign err_set_w   = (bus.add_shift & bus.shift) | (step_w & (state_q != RUN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            term_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_acc_w) begin
                step_err_q <= err_set_w;
            end else if (err_set_w) begin
                step_err_q <= 1'b1;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_acc_w) begin
                        state_q <= RUN;
                        term_q  <= bus.term;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (step_w) begin
                        if (count_q == term_q) begin
                            state_q <= DONE;
                            count_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_STEP_COUNTER_STATS_EN
    logic [WIDTH_C:0] add_steps_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            add_steps_q <= '0;
        end else if (start_acc_w) begin
            add_steps_q <= '0;
        end else if ((state_q == RUN) && bus.add_shift && !bus.abort) begin
            add_steps_q <= add_steps_q + 1'b1;
        end
    end

    assign bus.add_steps = add_steps_q;
`else
    assign bus.add_steps = '0;
`endif

    assign bus.count       = count_q;
    assign bus.count_check = (state_q == RUN) && (count_q == term_q);
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.step_err    = step_err_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_seq_step_counter.sv
// Directed bench for seq_step_counter: per-cycle expected outputs go through a scoreboard queue.
// add_steps expectations follow SEQ_STEP_COUNTER_STATS_EN as the design does.
module tb_seq_step_counter;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  logic [12:0] exp_q[$];
  string       name_q[$];

  seq_step_counter_if #(.WIDTH_C(4)) bus ();

  seq_step_counter #(.WIDTH_C(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] exp_add(input int n);
`ifdef SEQ_STEP_COUNTER_STATS_EN
    return 5'(n);
`else
    return (n >= 0) ? 5'd0 : 5'd0;
`endif
  endfunction

  // driver: apply inputs for one cycle, queue the outputs expected after that edge
  task automatic cyc(input logic rs, input logic st, input logic [3:0] tm,
                     input logic a, input logic s, input logic ab,
                     input logic [3:0] e_cnt, input logic e_cc, input logic e_bsy,
                     input logic e_dn, input logic e_err, input int e_add,
                     input string nm);
    reset         = rs;
    bus.start     = st;
    bus.term      = tm;
    bus.add_shift = a;
    bus.shift     = s;
    bus.abort     = ab;
    @(posedge clk);
    exp_q.push_back({e_cnt, e_cc, e_bsy, e_dn, e_err, exp_add(e_add)});
    name_q.push_back(nm);
    #1;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.term      = 4'd0;
    bus.add_shift = 1'b0;
    bus.shift     = 1'b0;
    bus.abort     = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [12:0] act;
    logic [12:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {bus.count, bus.count_check, bus.busy, bus.done, bus.step_err, bus.add_steps};
        n_cmp++;
        if (act !== exp) begin
          n_mis++;
          $display("FAIL %s: got cnt=%0d cc=%0b busy=%0b done=%0b err=%0b add=%0d, expected cnt=%0d cc=%0b busy=%0b done=%0b err=%0b add=%0d",
                   nm, act[12:9], act[8], act[7], act[6], act[5], act[4:0],
                   exp[12:9], exp[8], exp[7], exp[6], exp[5], exp[4:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.term = 4'd0; bus.add_shift = 1'b0; bus.shift = 1'b0; bus.abort = 1'b0;

    // full 16-step operation, alternating add_shift / shift
    cyc(1,0, 0,0,0,0, 0,0,0,0,0,0, "reset");
    cyc(0,1,15,0,0,0, 0,0,1,0,0,0, "t1_start");
    for (int i = 0; i < 15; i++)
      cyc(0,0,0, logic'(i % 2 == 0), logic'(i % 2 == 1), 0,
          4'(i + 1), logic'(i == 14), 1, 0, 0, i / 2 + 1, "t1_step");
    cyc(0,0, 0,0,1,0, 0,0,0,1,0,8, "t1_done");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,8, "t1_idle");

    // single-step op, then back-to-back start in the DONE cycle
    cyc(0,1, 0,0,0,0, 0,1,1,0,0,0, "t2_start_t0");
    cyc(0,0, 0,0,1,0, 0,0,0,1,0,0, "t2_done_t0");
    cyc(0,1, 2,0,0,0, 0,0,1,0,0,0, "t2_b2b_start");
    cyc(0,0, 0,1,0,0, 1,0,1,0,0,1, "t2_step1");
    cyc(0,0, 0,0,1,0, 2,1,1,0,0,1, "t2_step2");
    cyc(0,0, 0,1,0,0, 0,0,0,1,0,2, "t2_done_t2");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,2, "t2_idle");

    // abort with a step at count 5
    cyc(0,1, 9,0,0,0, 0,0,1,0,0,0, "t3_start");
    for (int i = 0; i < 5; i++)
      cyc(0,0,0,0,1,0, 4'(i + 1), 0,1,0,0,0, "t3_step");
    cyc(0,0, 0,1,0,1, 0,0,0,0,0,0, "t3_abort");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,0, "t3_no_done");
    cyc(0,1, 1,0,0,0, 0,0,1,0,0,0, "t3_restart");
    cyc(0,0, 0,0,1,0, 1,1,1,0,0,0, "t3_step1");
    cyc(0,0, 0,1,0,0, 0,0,0,1,0,1, "t3_done");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,1, "t3_idle");

    // step_err: both strobes in RUN, strobe in IDLE, start+abort in IDLE
    cyc(0,1, 4,0,0,0, 0,0,1,0,0,0, "t4_start");
    for (int i = 0; i < 3; i++)
      cyc(0,0,0,0,1,0, 4'(i + 1), 0,1,0,0,0, "t4_step");
    cyc(0,0, 0,1,1,0, 4,1,1,0,1,1, "t4_both");
    cyc(0,0, 0,0,1,0, 0,0,0,1,1,1, "t4_done_err");
    cyc(0,0, 0,0,0,0, 0,0,0,0,1,1, "t4_idle_err");
    cyc(0,1, 0,0,0,0, 0,1,1,0,0,0, "t4_start_clr");
    cyc(0,0, 0,0,1,0, 0,0,0,1,0,0, "t4_done2");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,0, "t4_idle2");
    cyc(0,0, 0,0,1,0, 0,0,0,0,1,0, "t4_idle_strobe");
    cyc(0,0, 0,0,0,0, 0,0,0,0,1,0, "t4_err_hold");
    cyc(0,1, 3,0,0,1, 0,0,0,0,1,0, "t4_start_abort");

    // reset mid-RUN at count 7
    cyc(0,1, 9,0,0,0, 0,0,1,0,0,0, "t5_start");
    for (int i = 0; i < 6; i++)
      cyc(0,0,0,1,0,0, 4'(i + 1), 0,1,0,0,i + 1, "t5_step");
    cyc(0,0, 0,1,1,0, 7,0,1,0,1,7, "t5_both");
    cyc(1,0, 0,1,0,0, 0,0,0,0,0,0, "t5_reset");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,0, "t5_after");

    // add_steps pattern A,S,A,A,S,S,A,S; start ignored in RUN
    cyc(0,1, 7,0,0,0, 0,0,1,0,0,0, "t6_start");
    cyc(0,0, 0,1,0,0, 1,0,1,0,0,1, "t6_a1");
    cyc(0,1, 0,0,1,0, 2,0,1,0,0,1, "t6_start_ign");
    cyc(0,0, 0,1,0,0, 3,0,1,0,0,2, "t6_a3");
    cyc(0,0, 0,1,0,0, 4,0,1,0,0,3, "t6_a4");
    cyc(0,0, 0,0,1,0, 5,0,1,0,0,3, "t6_s5");
    cyc(0,0, 0,0,1,0, 6,0,1,0,0,3, "t6_s6");
    cyc(0,0, 0,1,0,0, 7,1,1,0,0,4, "t6_a7");
    cyc(0,0, 0,0,1,0, 0,0,0,1,0,4, "t6_done");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,4, "t6_hold");
    cyc(0,1, 0,0,0,0, 0,1,1,0,0,0, "t6_clear");
    cyc(0,0, 0,0,1,0, 0,0,0,1,0,0, "t6_done2");
    cyc(0,0, 0,0,0,0, 0,0,0,0,0,0, "t6_idle");

    // drain, bounded
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
